herm_rmv_buf_ctrl: RTL

HERM_RMV_BUF_CTRL -- requirements
Module: herm_rmv_buf_ctrl

---
 rtl/herm_rmv_pkg.sv | 14 +
 rtl/herm_rmv_skid.sv | 83 ++++++++
 rtl/herm_rmv_buf_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/herm_rmv_pkg.sv
// Shared types and default sizing for the herm_rmv frame buffer controller.
package herm_rmv_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 9;
  localparam int FRAME_LEN_DEF = 336;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/herm_rmv_skid.sv
// Two-entry output holding stage (output register + skid) that absorbs the
// one-cycle buffer read latency while keeping the output stable under stall.
module herm_rmv_skid
  import herm_rmv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [1:0]        count
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_last_q,  out_last_d;
  logic              sk_valid_q,  sk_valid_d;
  logic [DATA_W-1:0] sk_data_q,   sk_data_d;
  logic              sk_last_q,   sk_last_d;
  logic              pop;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    sk_valid_d  = sk_valid_q;
    sk_data_d   = sk_data_q;
    sk_last_d   = sk_last_q;
    pop         = out_valid_q && out_ready;

    if (!out_valid_q || pop) begin
      if (sk_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = sk_data_q;
        out_last_d  = sk_last_q;
        sk_valid_d  = in_valid;
        sk_data_d   = in_data;
        sk_last_d   = in_last;
      end else begin
        out_valid_d = in_valid;
        if (in_valid) begin
          out_data_d = in_data;
          out_last_d = in_last;
        end
      end
    end else if (in_valid) begin
      // Caller only pushes here when the skid slot is known to be free.
      sk_valid_d = 1'b1;
      sk_data_d  = in_data;
      sk_last_d  = in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      sk_valid_q  <= 1'b0;
      sk_data_q   <= '0;
      sk_last_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      sk_valid_q  <= sk_valid_d;
      sk_data_q   <= sk_data_d;
      sk_last_q   <= sk_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign count     = {1'b0, out_valid_q} + {1'b0, sk_valid_q};

endmodule

// File: rtl/herm_rmv_buf_ctrl.sv
// Frame store-and-forward controller: fills an external single-port buffer
// from the write stream, then replays the frame on the read stream.
//
// state    | meaning
// ST_IDLE  | waiting for first beat of a frame, buffer address 0
// ST_FILL  | accepting beats, writing buffer at wr_cnt
// ST_DRAIN | write stream blocked, reading 0..last_addr out via skid
module herm_rmv_buf_ctrl
  import herm_rmv_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [DATA_W-1:0] m_data,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_di,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              frame_done,
  output logic              len_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  state_e            state_q, state_d;
  logic              run_q, run_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              rd_done_q, rd_done_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_pend_last_q, rd_pend_last_d;

  logic [1:0]        skid_cnt;
  logic [1:0]        occ;
  logic              pop;
  logic              can_issue;

  herm_rmv_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_pend_q),
    .in_data   (bram_dout),
    .in_last   (rd_pend_last_q),
    .out_valid (m_valid),
    .out_data  (m_data),
    .out_last  (m_last),
    .out_ready (m_ready),
    .count     (skid_cnt)
  );

  always_comb begin
    state_d        = state_q;
    run_d          = 1'b1;
    wr_cnt_d       = wr_cnt_q;
    last_addr_d    = last_addr_q;
    rd_cnt_d       = rd_cnt_q;
    rd_done_d      = rd_done_q;
    rd_pend_d      = 1'b0;
    rd_pend_last_d = 1'b0;
    s_ready        = 1'b0;
    bram_en        = 1'b0;
    bram_we        = 1'b0;
    bram_addr      = '0;
    bram_di        = '0;
    frame_done     = 1'b0;
    len_err        = 1'b0;
    pop            = m_valid && m_ready;
    // Slots already committed: held samples plus the read still in flight.
    occ            = skid_cnt + {1'b0, rd_pend_q};
    can_issue      = !rd_done_q && ((occ < 2'd2) || (pop && occ == 2'd2));

    case (state_q)
      ST_IDLE, ST_FILL: begin
        s_ready = run_q;
        if (s_valid && run_q) begin
          bram_en   = 1'b1;
          bram_we   = 1'b1;
          bram_addr = wr_cnt_q;
          bram_di   = s_data;
          if (s_last || wr_cnt_q == LAST_ADDR) begin
            len_err     = !s_last;
            last_addr_d = wr_cnt_q;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            rd_done_d   = 1'b0;
            state_d     = ST_DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            state_d  = ST_FILL;
          end
        end
      end
      ST_DRAIN: begin
        if (can_issue) begin
          bram_en        = 1'b1;
          bram_addr      = rd_cnt_q;
          rd_pend_d      = 1'b1;
          rd_pend_last_d = (rd_cnt_q == last_addr_q);
          if (rd_cnt_q == last_addr_q) rd_done_d = 1'b1;
          else                         rd_cnt_d  = rd_cnt_q + 1'b1;
        end
        if (pop && m_last) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      run_q          <= 1'b0;
      wr_cnt_q       <= '0;
      last_addr_q    <= '0;
      rd_cnt_q       <= '0;
      rd_done_q      <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_q          <= run_d;
      wr_cnt_q       <= wr_cnt_d;
      last_addr_q    <= last_addr_d;
      rd_cnt_q       <= rd_cnt_d;
      rd_done_q      <= rd_done_d;
      rd_pend_q      <= rd_pend_d;
      rd_pend_last_q <= rd_pend_last_d;
    end
  end

endmodule
